// File: rtl/toy_pkg.sv
// Shared definitions for the Toy multi-cycle sequencer: opcodes, ALU and
// PC-source codes, FSM state encodings and the decoded-opcode record.
package toy_pkg;

    // Opcodes as seen on IR[15:12]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_ILL7 = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STT  = 4'hB;
    localparam logic [3:0] OP_MOVT = 4'hC;
    localparam logic [3:0] OP_JI   = 4'hD;
    localparam logic [3:0] OP_ILLE = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operation select
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // PC source mux select
    localparam logic [1:0] SRC_PC_INC = 2'b00;
    localparam logic [1:0] SRC_PC_IR  = 2'b01;
    localparam logic [1:0] SRC_PC_MEM = 2'b10;

    // Sequencer states; the encoding is visible on state_dbg
    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERR    = 3'd6,
        ST_PAUSE  = 3'd7
    } state_t;

    // Where DECODE sends an instruction
    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_MEM  = 3'd1,
        CLS_EXEC = 3'd2,
        CLS_HALT = 3'd3,
        CLS_ILL  = 3'd4
    } op_class_t;

    // Decoded controls for the memory phase of an instruction
    typedef struct packed {
        op_class_t  cls;
        logic       rd;
        logic       wr;
        logic       src_adr;
        logic       src_data;
        logic       ack_wr_a;
        logic       src_a;
        logic       ack_pc_we;
        logic [2:0] alu_op;
    } dec_t;

endpackage

// File: rtl/toy_op_decode.sv
// Combinational opcode decoder: classifies the instruction and derives the
// data-memory request, mux selects and completion strobes of its MEM phase.
module toy_op_decode
    import toy_pkg::*;
(
    input  logic [3:0] opcode,
    output dec_t       dec
);

    // Map each opcode to its class and memory-phase controls.
    always_comb begin
        dec     = '0;
        dec.cls = CLS_ILL;
        case (opcode)
            OP_NOP:  dec.cls = CLS_NOP;
            OP_LDA: begin
                dec.cls      = CLS_MEM;
                dec.rd       = 1'b1;
                dec.ack_wr_a = 1'b1;
                dec.src_a    = 1'b1;
            end
            OP_STA: begin
                dec.cls      = CLS_MEM;
                dec.wr       = 1'b1;
                dec.src_data = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec.cls      = CLS_MEM;
                dec.rd       = 1'b1;
                dec.ack_wr_a = 1'b1;
                // 3..6 map onto ALU_ADD..ALU_OR
                dec.alu_op   = opcode[2:0] - 3'd3;
            end
            OP_JMP, OP_JZ, OP_MOVT: dec.cls = CLS_EXEC;
            OP_LDI: begin
                dec.cls      = CLS_MEM;
                dec.rd       = 1'b1;
                dec.src_adr  = 1'b1;
                dec.ack_wr_a = 1'b1;
                dec.src_a    = 1'b1;
            end
            OP_STT: begin
                dec.cls      = CLS_MEM;
                dec.wr       = 1'b1;
            end
            OP_JI: begin
                dec.cls       = CLS_MEM;
                dec.rd        = 1'b1;
                dec.ack_pc_we = 1'b1;
            end
            OP_HALT:          dec.cls = CLS_HALT;
            OP_ILL7, OP_ILLE: dec.cls = CLS_ILL;
            default:          dec.cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/toy_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/EXEC sequencer for the Toy accumulator
// datapath, with req/ack memory handshakes, a wait-cycle timeout, and
// terminal HALT/ERR states.
// Build option: define TOY_SSTEP_EN to park in PAUSE after every
// instruction (and after boot) until the step input is high.
module toy_mc_sequencer
    import toy_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       a_zero,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       step,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] src_pc,
    output logic [2:0] alu_op,
    output logic       wr_a,
    output logic       src_a,
    output logic       wr_t,
    output logic       rd_dmem,
    output logic       wr_dmem,
    output logic       src_adr,
    output logic       src_data,
    output logic       halted,
    output logic       err,
    output logic [2:0] state_dbg
);

`ifdef TOY_SSTEP_EN
    localparam state_t DONE_ST = ST_PAUSE;
`else
    localparam state_t DONE_ST = ST_FETCH;
    logic unused_step_s;
    assign unused_step_s = step;
`endif

    state_t          state_r;
    state_t          state_nx_s;
    logic [TO_W-1:0] to_cnt_r;
    logic            to_hit_s;
    dec_t            dec_s;

    toy_op_decode u_dec (
        .opcode (opcode),
        .dec    (dec_s)
    );

    // The cycle that would make the wait count reach MEM_TIMEOUT.
    assign to_hit_s = (to_cnt_r == TO_W'(MEM_TIMEOUT - 1));

    // State register; reset parks the FSM in BOOT so every strobe drops at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Wait-cycle counter: cleared on any state change, counts cycles spent waiting in FETCH/MEM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if (state_nx_s != state_r) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == ST_FETCH) || (state_r == ST_MEM)) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Next-state and strobe generation; an ack in the timeout cycle still completes.
    always_comb begin
        state_nx_s = state_r;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        src_pc     = SRC_PC_INC;
        alu_op     = ALU_ADD;
        wr_a       = 1'b0;
        src_a      = 1'b0;
        wr_t       = 1'b0;
        rd_dmem    = 1'b0;
        wr_dmem    = 1'b0;
        src_adr    = 1'b0;
        src_data   = 1'b0;
        case (state_r)
            ST_BOOT: state_nx_s = DONE_ST;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    src_pc     = SRC_PC_INC;
                    state_nx_s = ST_DECODE;
                end else if (to_hit_s) begin
                    state_nx_s = ST_ERR;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (dec_s.cls)
                    CLS_NOP:  state_nx_s = DONE_ST;
                    CLS_MEM:  state_nx_s = ST_MEM;
                    CLS_EXEC: state_nx_s = ST_EXEC;
                    CLS_HALT: state_nx_s = ST_HALT;
                    CLS_ILL:  state_nx_s = ST_ERR;
                    default:  state_nx_s = ST_ERR;
                endcase
            end
            ST_MEM: begin
                rd_dmem  = dec_s.rd;
                wr_dmem  = dec_s.wr;
                src_adr  = dec_s.src_adr;
                src_data = dec_s.src_data;
                if (dmem_ack) begin
                    wr_a       = dec_s.ack_wr_a;
                    src_a      = dec_s.src_a;
                    alu_op     = dec_s.alu_op;
                    pc_we      = dec_s.ack_pc_we;
                    src_pc     = dec_s.ack_pc_we ? SRC_PC_MEM : SRC_PC_INC;
                    state_nx_s = DONE_ST;
                end else if (to_hit_s) begin
                    state_nx_s = ST_ERR;
                end else begin
                    state_nx_s = ST_MEM;
                end
            end
            ST_EXEC: begin
                state_nx_s = DONE_ST;
                case (opcode)
                    OP_JMP: begin
                        pc_we  = 1'b1;
                        src_pc = SRC_PC_IR;
                    end
                    OP_JZ: begin
                        pc_we  = a_zero;
                        src_pc = SRC_PC_IR;
                    end
                    OP_MOVT: wr_t = 1'b1;
                    default: state_nx_s = ST_ERR;
                endcase
            end
            ST_HALT: state_nx_s = ST_HALT;
            ST_ERR:  state_nx_s = ST_ERR;
`ifdef TOY_SSTEP_EN
            ST_PAUSE: begin
                if (step) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_PAUSE;
                end
            end
`else
            ST_PAUSE: state_nx_s = ST_ERR;
`endif
            default: state_nx_s = ST_ERR;
        endcase
    end

    assign halted    = (state_r == ST_HALT);
    assign err       = (state_r == ST_ERR);
    assign state_dbg = state_r;

endmodule

// File: tb/tb_toy_mc_sequencer.sv
// Self-checking bench: a behavioural Toy datapath with variable-latency
// memories follows the sequencer's strobes; expected architectural writes
// are queued per program and matched as the strobes appear.
module tb_toy_mc_sequencer;
    import toy_pkg::*;

    logic       clk, reset;
    logic [3:0] opcode;
    logic       a_zero, imem_ack, dmem_ack, step;
    logic       imem_req, ir_we, pc_we, wr_a, src_a, wr_t;
    logic       rd_dmem, wr_dmem, src_adr, src_data, halted, err;
    logic [1:0] src_pc;
    logic [2:0] alu_op, state_dbg;

    toy_mc_sequencer #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .a_zero(a_zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .step(step),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .src_pc(src_pc),
        .alu_op(alu_op), .wr_a(wr_a), .src_a(src_a), .wr_t(wr_t),
        .rd_dmem(rd_dmem), .wr_dmem(wr_dmem), .src_adr(src_adr),
        .src_data(src_data), .halted(halted), .err(err), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TOY_SSTEP_EN
    localparam int PAUSE_CYC = 1;
`else
    localparam int PAUSE_CYC = 0;
`endif

    localparam logic [1:0] K_A = 2'd0, K_T = 2'd1, K_PC = 2'd2, K_M = 2'd3;
    typedef struct packed { logic [1:0] kind; logic [31:0] val; } exp_t;

    int          total, bad, cyc;
    int          i_lat, d_lat, i_wait, d_wait, rd_cycles, wr_a_cycles;
    logic [15:0] imem [0:4095];
    logic [15:0] dmem [0:4095];
    logic [11:0] pc;
    logic [15:0] ir, a, t;
    exp_t        sb_q[$];

    task automatic push(input logic [1:0] k, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) begin
            imem[i] = 16'hF000;
            dmem[i] = 16'h0000;
        end
    endtask

    task automatic reset_dut(input int il, input int dl);
        reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; step = 1'b1;
        pc = 12'h000; ir = 16'h0000; a = 16'h0000; t = 16'h0000;
        opcode = 4'h0; a_zero = 1'b1;
        i_lat = il; d_lat = dl; i_wait = 0; d_wait = 0;
        rd_cycles = 0; wr_a_cycles = 0;
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: answer requests, match strobes against the scoreboard, advance the datapath.
    task automatic tick();
        logic [11:0] adr, pc_n;
        logic [15:0] rdata, wdata, alu, a_n;
        logic        s_req, s_iack, s_dreq, s_dack, s_ir_we, s_pc_we, s_wr_a, s_wr_t, s_wr;
        exp_t        e;
        exp_t        ev[$];
        imem_ack = imem_req && (i_wait >= i_lat);
        dmem_ack = (rd_dmem || wr_dmem) && (d_wait >= d_lat);
        #1;
        adr   = src_adr ? a[11:0] : ir[11:0];
        rdata = dmem[adr];
        wdata = src_data ? a : t;
        case (alu_op)
            3'd0:    alu = a + rdata;
            3'd1:    alu = a - rdata;
            3'd2:    alu = a & rdata;
            default: alu = a | rdata;
        endcase
        a_n = src_a ? rdata : alu;
        case (src_pc)
            2'd1:    pc_n = ir[11:0];
            2'd2:    pc_n = rdata[11:0];
            default: pc_n = pc + 12'd1;
        endcase
        total++;
        if ((rd_dmem && wr_dmem) || (ir_we && (wr_a || wr_t)) || (wr_a && !dmem_ack) ||
            (ir_we && !(pc_we && src_pc == 2'd0 && imem_ack))) begin
            bad++;
            $display("FAIL invariant cyc=%0d got rd=%b wr=%b ir_we=%b wr_a=%b wr_t=%b pc_we=%b src_pc=%0d dack=%b iack=%b",
                     cyc, rd_dmem, wr_dmem, ir_we, wr_a, wr_t, pc_we, src_pc, dmem_ack, imem_ack);
        end
        if (rd_dmem) rd_cycles++;
        if (wr_a) wr_a_cycles++;
        if (wr_a) begin e.kind = K_A; e.val = {16'h0, a_n}; ev.push_back(e); end
        if (wr_t) begin e.kind = K_T; e.val = {16'h0, a}; ev.push_back(e); end
        if (pc_we && !ir_we) begin e.kind = K_PC; e.val = {20'h0, pc_n}; ev.push_back(e); end
        if (wr_dmem && dmem_ack) begin e.kind = K_M; e.val = {4'h0, adr, wdata}; ev.push_back(e); end
        foreach (ev[i]) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected cyc=%0d got kind=%0d val=%h want nothing", cyc, ev[i].kind, ev[i].val);
            end else begin
                e = sb_q.pop_front();
                if (ev[i] !== e) begin
                    bad++;
                    $display("FAIL sb_write cyc=%0d got kind=%0d val=%h want kind=%0d val=%h",
                             cyc, ev[i].kind, ev[i].val, e.kind, e.val);
                end
            end
        end
        s_req = imem_req; s_iack = imem_ack; s_dreq = rd_dmem || wr_dmem; s_dack = dmem_ack;
        s_ir_we = ir_we; s_pc_we = pc_we; s_wr_a = wr_a; s_wr_t = wr_t; s_wr = wr_dmem;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        i_wait = (s_req && !s_iack) ? i_wait + 1 : 0;
        d_wait = (s_dreq && !s_dack) ? d_wait + 1 : 0;
        if (s_wr && s_dack) dmem[adr] = wdata;
        if (s_ir_we) ir = imem[pc];
        if (s_wr_t) t = a;
        if (s_wr_a) a = a_n;
        if (s_pc_we) pc = pc_n;
        opcode = ir[15:12];
        a_zero = (a == 16'h0000);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to_stop(input int budget);
        int n;
        n = 0;
        while (!halted && !err && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (!halted && !err) begin
            bad++;
            $display("FAIL run_budget got state=%0d after %0d cycles want halted or err", state_dbg, n);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; step = 1'b1; opcode = 4'h1; a_zero = 1'b0;
        @(negedge clk);
        total++;
        if ({imem_req, ir_we, pc_we, src_pc, alu_op, wr_a, src_a, wr_t, rd_dmem, wr_dmem,
             src_adr, src_data, halted, err, state_dbg} !== 22'h0) begin
            bad++;
            $display("FAIL reset_outputs got imem_req=%b rd=%b state=%0d want all zero", imem_req, rd_dmem, state_dbg);
        end
        reset_dut(0, 0);
        total++;
        if (state_dbg !== 3'd0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL boot_state got state=%0d req=%b want 0 0", state_dbg, imem_req);
        end
        tick();
        total++;
        if (state_dbg !== ((PAUSE_CYC == 1) ? ST_PAUSE : ST_FETCH) || imem_req !== (PAUSE_CYC == 0)) begin
            bad++;
            $display("FAIL boot_exit got state=%0d req=%b", state_dbg, imem_req);
        end
    endtask

    task automatic test_lda_add();
        clear_mem();
        imem[0] = 16'h1010; imem[1] = 16'h3011; imem[2] = 16'hF000;
        dmem[12'h010] = 16'd5; dmem[12'h011] = 16'd7;
        reset_dut(0, 0);
        push(K_A, 32'd5); push(K_A, 32'd12);
        repeat (1 + PAUSE_CYC) tick();
        repeat (3) tick();
        total++;
        if (a !== 16'd5) begin bad++; $display("FAIL lda_3cyc got A=%h want 0005", a); end
        repeat (3 + PAUSE_CYC) tick();
        total++;
        if (a !== 16'd12) begin bad++; $display("FAIL add_6cyc got A=%h want 000c", a); end
        repeat (2 + PAUSE_CYC) tick();
        total++;
        if (halted !== 1'b1 || err !== 1'b0 || pc !== 12'h003) begin
            bad++;
            $display("FAIL halt got halted=%b err=%b pc=%h want 1 0 003", halted, err, pc);
        end
        repeat (3) tick();
        total++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL halt_sticky got halted=%b req=%b pending=%0d want 1 0 0", halted, imem_req, sb_q.size());
        end
    endtask

    task automatic test_dmem_wait();
        clear_mem();
        imem[0] = 16'h1010; imem[1] = 16'hF000;
        dmem[12'h010] = 16'd5;
        reset_dut(0, 3);
        push(K_A, 32'd5);
        run_to_stop(60);
        total++;
        if (rd_cycles != 4 || wr_a_cycles != 1 || a !== 16'd5 || halted !== 1'b1 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL dmem_wait got rd_cycles=%0d wr_a_cycles=%0d A=%h halted=%b want 4 1 0005 1",
                     rd_cycles, wr_a_cycles, a, halted);
        end
    endtask

    task automatic test_jumps();
        clear_mem();
        imem[0] = 16'h9005;
        imem[5] = 16'h1010; imem[6] = 16'h900A; imem[7] = 16'hD020;
        imem[12'h00A] = 16'h0000;
        imem[12'h123] = 16'hF000;
        dmem[12'h010] = 16'd5; dmem[12'h020] = 16'h0123;
        reset_dut(1, 1);
        push(K_PC, 32'h005); push(K_A, 32'd5); push(K_PC, 32'h123);
        run_to_stop(150);
        total++;
        if (pc !== 12'h124 || halted !== 1'b1 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL jumps got pc=%h halted=%b pending=%0d want 124 1 0", pc, halted, sb_q.size());
        end
    endtask

    task automatic test_alu_store();
        clear_mem();
        imem[0] = 16'h1010; imem[1] = 16'hC000; imem[2] = 16'h4011; imem[3] = 16'h2030;
        imem[4] = 16'hB031; imem[5] = 16'h5012; imem[6] = 16'h6013; imem[7] = 16'hA000;
        imem[8] = 16'h800A; imem[9] = 16'h7000;
        dmem[12'h010] = 16'd5; dmem[12'h011] = 16'd7; dmem[12'h012] = 16'h00F0;
        dmem[12'h013] = 16'h0F01; dmem[12'hFF1] = 16'h4242;
        reset_dut(2, 2);
        push(K_A, 32'h0005); push(K_T, 32'h0005); push(K_A, 32'hFFFE);
        push(K_M, 32'h030FFFE); push(K_M, 32'h0310005);
        push(K_A, 32'h00F0); push(K_A, 32'h0FF1); push(K_A, 32'h4242); push(K_PC, 32'h00A);
        run_to_stop(300);
        total++;
        if (halted !== 1'b1 || pc !== 12'h00B || a !== 16'h4242 || t !== 16'h0005 ||
            dmem[12'h030] !== 16'hFFFE || dmem[12'h031] !== 16'h0005 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL alu_store got halted=%b pc=%h A=%h T=%h m30=%h m31=%h want 1 00b 4242 0005 fffe 0005",
                     halted, pc, a, t, dmem[12'h030], dmem[12'h031]);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] op;
        for (int i = 0; i < 2; i++) begin
            op = (i == 0) ? 4'h7 : 4'hE;
            clear_mem();
            imem[0] = {op, 12'h000};
            reset_dut(0, 0);
            repeat (2 + PAUSE_CYC) tick();
            total++;
            if (err !== 1'b0 || state_dbg !== ST_DECODE) begin
                bad++;
                $display("FAIL illegal_decode op=%h got err=%b state=%0d want 0 decode", op, err, state_dbg);
            end
            tick();
            total++;
            if (err !== 1'b1) begin bad++; $display("FAIL illegal_err op=%h got err=%b want 1", op, err); end
            imem_ack = 1'b1; dmem_ack = 1'b1; step = 1'b1;
            @(posedge clk); #1;
            imem_ack = 1'b0; dmem_ack = 1'b0;
            @(negedge clk);
            repeat (4) tick();
            total++;
            if (err !== 1'b1 || halted !== 1'b0 || imem_req !== 1'b0 || state_dbg !== ST_ERR) begin
                bad++;
                $display("FAIL err_sticky op=%h got err=%b halted=%b req=%b want 1 0 0", op, err, halted, imem_req);
            end
        end
    endtask

    task automatic test_timeout();
        clear_mem();
        imem[0] = 16'h1010; imem[1] = 16'hF000;
        dmem[12'h010] = 16'd5;
        reset_dut(0, 15);
        repeat (3 + PAUSE_CYC) tick();
        repeat (14) tick();
        total++;
        if (err !== 1'b0 || rd_dmem !== 1'b1) begin
            bad++;
            $display("FAIL dmem_wait14 got err=%b rd=%b want 0 1", err, rd_dmem);
        end
        tick();
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL dmem_timeout got err=%b want 1", err); end
        reset_dut(0, 14);
        push(K_A, 32'd5);
        run_to_stop(60);
        total++;
        if (halted !== 1'b1 || err !== 1'b0 || a !== 16'd5 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL ack_wins got halted=%b err=%b A=%h want 1 0 0005", halted, err, a);
        end
        reset_dut(15, 0);
        repeat (1 + PAUSE_CYC) tick();
        repeat (14) tick();
        total++;
        if (err !== 1'b0 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL imem_wait14 got err=%b req=%b want 0 1", err, imem_req);
        end
        tick();
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL imem_timeout got err=%b want 1", err); end
    endtask

    task automatic test_reset_mid_mem();
        clear_mem();
        imem[0] = 16'h1010;
        reset_dut(0, 10);
        repeat (5 + PAUSE_CYC) tick();
        total++;
        if (rd_dmem !== 1'b1) begin bad++; $display("FAIL mid_mem_rd got rd=%b want 1", rd_dmem); end
        reset = 1'b1;
        #1;
        total++;
        if (rd_dmem !== 1'b0 || state_dbg !== 3'd0) begin
            bad++;
            $display("FAIL async_reset got rd=%b state=%0d want 0 0", rd_dmem, state_dbg);
        end
        reset_dut(0, 0);
`ifdef TOY_SSTEP_EN
        step = 1'b0;
        repeat (3) tick();
        total++;
        if (imem_req !== 1'b0 || state_dbg !== ST_PAUSE) begin
            bad++;
            $display("FAIL pause_hold got req=%b state=%0d want 0 pause", imem_req, state_dbg);
        end
        step = 1'b1;
`endif
        tick();
        total++;
        if (imem_req !== 1'b1 || state_dbg !== ST_FETCH) begin
            bad++;
            $display("FAIL refetch got req=%b state=%0d want 1 fetch", imem_req, state_dbg);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got time=%0t want completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0; cyc = 0;
        test_reset();
        test_lda_add();
        test_dmem_wait();
        test_jumps();
        test_alu_store();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
